// File: rtl/bist_pkg.sv
// Shared types for the SRAM BIST controller: test pattern selection and
// controller FSM states.
package bist_pattern_sel;

    typedef enum logic [1:0] {
        ZERO_ONE,
        CHECKERBOARD,
        MARCH_CM_ENHANCED
    } pattern_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

endpackage

// File: rtl/bist_if.sv
// Connection bundle between the BIST controller and one SRAM macro.
interface bist_if
    import bist_pattern_sel::*;
#(
    parameter int MAX_ADDR   = 63,
    parameter int DATA_WIDTH = 8,
    parameter int MASK_WIDTH = 2
) (
    input logic clk
);
    localparam int AddrWidth = $clog2(MAX_ADDR);

    logic                  rst;
    logic                  en;
    pattern_t              pattern_sel;
    logic                  we;
    logic                  re;
    logic [AddrWidth-1:0]  addr;
    logic [DATA_WIDTH-1:0] din;
    logic [MASK_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] check;
    logic [DATA_WIDTH-1:0] dout;
    logic                  done;
    logic                  fail;
    pattern_t              test_pattern;

    modport bist (
        input  clk, rst, en, pattern_sel, dout,
        output we, re, addr, din, wmask, check, done, fail, test_pattern
    );

    modport sram (
        input  clk, we, re, addr, din, wmask, check, done, fail, test_pattern,
        output rst, en, pattern_sel, dout
    );

endinterface

// File: rtl/bist_march_gen.sv
// Sequence generator: walks pattern -> element -> address (-> op within a
// two-operation element) and presents the operation to issue this cycle.
module bist_march_gen
    import bist_pattern_sel::*;
#(
    parameter int MAX_ADDR  = 63,
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 8,
    parameter int MUX_RATIO = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  pattern_t          pattern_sel,
    input  logic              step,
    output logic              valid,
    output pattern_t          pattern,
    output logic              is_write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              last
);
    // Lowest row bit sits just above the column-select bits.
    localparam int ColBits = $clog2(MUX_RATIO);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MAX_ADDR);

    pattern_t          pat_q, pat_d;
    logic [2:0]        elem_q, elem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              phase_q, phase_d;
    logic              fin_q, fin_d;

    logic two_op, desc, next_desc, last_elem, at_end, bit_val;

    // Decode the current element: direction, op kind and data polarity
    always_comb begin
        two_op    = 1'b0;
        desc      = 1'b0;
        next_desc = 1'b0;
        last_elem = 1'b0;
        is_write  = 1'b0;
        bit_val   = 1'b0;
        case (pat_q)
            ZERO_ONE: begin
                is_write  = ~elem_q[0];
                bit_val   = elem_q[1];
                last_elem = (elem_q == 3'd3);
            end
            CHECKERBOARD: begin
                is_write  = ~elem_q[0];
                bit_val   = elem_q[1] ^ addr_q[ColBits] ^ addr_q[0];
                last_elem = (elem_q == 3'd3);
            end
            default: begin
                two_op    = (elem_q >= 3'd1) && (elem_q <= 3'd4);
                desc      = (elem_q == 3'd3) || (elem_q == 3'd4);
                next_desc = (elem_q == 3'd2) || (elem_q == 3'd3);
                is_write  = (elem_q == 3'd0) || (two_op && phase_q);
                bit_val   = ((elem_q == 3'd2) || (elem_q == 3'd4)) ^ phase_q;
                last_elem = (elem_q == 3'd5);
            end
        endcase
        at_end   = desc ? (addr_q == '0) : (addr_q == LastAddr);
        valid    = ~fin_q;
        pattern  = pat_q;
        addr     = addr_q;
        data     = {DATA_W{bit_val}};
        last     = (pat_q == MARCH_CM_ENHANCED) && last_elem && at_end;
    end

    // Advance to the next operation whenever one is issued
    always_comb begin
        pat_d   = pat_q;
        elem_d  = elem_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        fin_d   = fin_q;
        if (step && !fin_q) begin
            if (two_op && !phase_q) begin
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (!at_end) begin
                    addr_d = desc ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
                end else if (!last_elem) begin
                    elem_d = elem_q + 3'd1;
                    addr_d = next_desc ? LastAddr : '0;
                end else begin
                    elem_d = 3'd0;
                    addr_d = '0;
                    case (pat_q)
                        ZERO_ONE:     pat_d = CHECKERBOARD;
                        CHECKERBOARD: pat_d = MARCH_CM_ENHANCED;
                        default:      fin_d = 1'b1;
                    endcase
                end
            end
        end
    end

    // Sequence position registers; reset reloads the starting pattern
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= pattern_sel;
            elem_q  <= 3'd0;
            addr_q  <= '0;
            phase_q <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            fin_q   <= fin_d;
        end
    end

endmodule

// File: rtl/bist.sv
// SRAM BIST controller: issues the generated operations, registers the
// expected word of each read, compares it against SRAM data one cycle later
// and reports done/fail with the pattern that was running.
module bist
    import bist_pattern_sel::*;
#(
    parameter int MUX_RATIO = 4
) (
    bist_if.bist b
);
    localparam int MaxAddr = b.MAX_ADDR;
    localparam int AW      = $bits(b.addr);
    localparam int DW      = $bits(b.din);

    state_t          state_q, state_d;
    logic            rd_pend_q, rd_pend_d;
    logic            last_rd_q, last_rd_d;
    logic [DW-1:0]   check_q, check_d;
    pattern_t        rd_pat_q, rd_pat_d;
    logic            done_q, done_d;
    logic            fail_q, fail_d;
    pattern_t        fail_pat_q, fail_pat_d;

    logic            gen_valid, gen_we, gen_last;
    pattern_t        gen_pat;
    logic [AW-1:0]   gen_addr;
    logic [DW-1:0]   gen_data;
    logic            mismatch, final_ok, issue;

    bist_march_gen #(
        .MAX_ADDR  (MaxAddr),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MUX_RATIO (MUX_RATIO)
    ) u_gen (
        .clk         (b.clk),
        .rst         (b.rst),
        .pattern_sel (b.pattern_sel),
        .step        (issue),
        .valid       (gen_valid),
        .pattern     (gen_pat),
        .is_write    (gen_we),
        .addr        (gen_addr),
        .data        (gen_data),
        .last        (gen_last)
    );

    // Strobes, comparator and next-state; a detected mismatch blocks issue at once
    always_comb begin
        mismatch   = rd_pend_q && (b.dout != check_q);
        final_ok   = rd_pend_q && last_rd_q && !mismatch;
        issue      = !b.rst && b.en && (state_q != S_DONE) && !mismatch && gen_valid;

        b.we       = 1'b0;
        b.re       = 1'b0;
        b.addr     = '0;
        b.din      = '0;
        b.wmask    = '0;
        b.check    = '0;
        check_d    = '0;
        if (issue) begin
            b.addr = gen_addr;
            if (gen_we) begin
                b.we    = 1'b1;
                b.din   = gen_data;
                b.wmask = '1;
            end else begin
                b.re    = 1'b1;
                b.check = gen_data;
                check_d = gen_data;
            end
        end

        rd_pend_d  = issue && !gen_we;
        last_rd_d  = issue && !gen_we && gen_last;
        rd_pat_d   = gen_pat;
        done_d     = done_q | mismatch | final_ok;
        fail_d     = fail_q | mismatch;
        fail_pat_d = mismatch ? rd_pat_q : fail_pat_q;

        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue) state_d = S_RUN;
            S_RUN:   if (mismatch || final_ok) state_d = S_DONE;
            default: state_d = state_q;
        endcase

        b.done         = done_q;
        b.fail         = fail_q;
        b.test_pattern = fail_q ? fail_pat_q : gen_pat;
    end

    // Control state: FSM, read-pending pipeline flags and sticky status
    always_ff @(posedge b.clk) begin
        if (b.rst) begin
            state_q   <= S_IDLE;
            rd_pend_q <= 1'b0;
            last_rd_q <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
            last_rd_q <= last_rd_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
        end
    end

    // Read pipeline data: expected word and issuing pattern, qualified by rd_pend_q
    always_ff @(posedge b.clk) begin
        check_q    <= check_d;
        rd_pat_q   <= rd_pat_d;
        fail_pat_q <= fail_pat_d;
    end

endmodule

// File: tb/tb_bist.sv
// Bench for the SRAM BIST controller: acts as the SRAM, predicts every
// cycle's strobes and status from an operation list built from the pattern
// definitions, and injects read corruptions.
module tb_bist;
    import bist_pattern_sel::*;

    localparam int N   = 64;
    localparam int MUX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    bist_if #(.MAX_ADDR(63), .DATA_WIDTH(8), .MASK_WIDTH(2)) bi (.clk(clk));
    bist #(.MUX_RATIO(MUX)) dut (.b(bi));

    typedef struct {
        bit         w;
        int         a;
        logic [7:0] d;
        pattern_t   p;
    } op_t;

    op_t        exp_q[$];
    logic [7:0] mem [N];
    int         total = 0;
    int         bad   = 0;

    function automatic void push_op(bit w, int a, logic [7:0] d, pattern_t p);
        op_t o;
        o.w = w; o.a = a; o.d = d; o.p = p;
        exp_q.push_back(o);
    endfunction

    function automatic void march_pair(bit desc, logic [7:0] v);
        for (int i = 0; i < N; i++) begin
            int a = desc ? N - 1 - i : i;
            push_op(1'b0, a, v, MARCH_CM_ENHANCED);
            push_op(1'b1, a, ~v, MARCH_CM_ENHANCED);
        end
    endfunction

    // Full expected operation stream from the chosen start pattern onward
    function automatic void build(pattern_t sel);
        exp_q.delete();
        if (sel == ZERO_ONE)
            for (int e = 0; e < 4; e++)
                for (int a = 0; a < N; a++)
                    push_op(e % 2 == 0, a, (e >= 2) ? 8'hFF : 8'h00, ZERO_ONE);
        if (sel != MARCH_CM_ENHANCED)
            for (int e = 0; e < 4; e++)
                for (int a = 0; a < N; a++) begin
                    int pb = ((a / MUX) % 2) ^ ((a % MUX) % 2);
                    push_op(e % 2 == 0, a, ((pb ^ int'(e >= 2)) != 0) ? 8'hFF : 8'h00,
                            CHECKERBOARD);
                end
        for (int a = 0; a < N; a++) push_op(1'b1, a, 8'h00, MARCH_CM_ENHANCED);
        march_pair(1'b0, 8'h00);
        march_pair(1'b0, 8'hFF);
        march_pair(1'b1, 8'h00);
        march_pair(1'b1, 8'hFF);
        for (int a = 0; a < N; a++) push_op(1'b0, a, 8'h00, MARCH_CM_ENHANCED);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // cmode: 0 clean, 1 corrupt every read, 2 corrupt one random read
    task automatic run_case(input string name, input pattern_t sel, input int stall_pct,
                            input int stall_at, input int stall_len, input int cmode,
                            output int done_cyc, output int fail_cyc);
        int nreads, corrupt_rd, idx, rdno, exp_at, n, bad0;
        bit halt, fail_exp, en_now, finished;
        bit resp_pend, resp_bad, resp_final, cur_resp;
        int resp_addr;
        pattern_t resp_pat, fpat;
        logic [31:0] obs, expv;
        logic [1:0] tp_obs, tp_exp;
        op_t op;

        build(sel);
        nreads = 0;
        foreach (exp_q[i]) if (!exp_q[i].w) nreads++;
        corrupt_rd = (cmode == 2) ? int'($urandom_range(0, nreads - 1)) : -1;
        done_cyc = -1; fail_cyc = -1;

        bi.rst = 1'b1; bi.en = 1'b0; bi.pattern_sel = sel; bi.dout = 8'h00;
        repeat (16) @(posedge clk);
        @(negedge clk);
        check({name, " reset outputs"},
              {bi.we, bi.re, bi.addr, bi.din, bi.wmask, bi.check, bi.done, bi.fail}, 0);
        check({name, " reset test_pattern"}, bi.test_pattern, sel);

        idx = 0; rdno = 0; exp_at = -1; halt = 0; fail_exp = 0; fpat = MARCH_CM_ENHANCED;
        resp_pend = 0; resp_bad = 0; resp_final = 0; resp_addr = 0; resp_pat = sel;
        finished = 0; bad0 = bad;
        for (n = 0; n < 4000; n++) begin
            @(posedge clk); #1;
            bi.rst = 1'b0;
            en_now = !(n >= stall_at && n < stall_at + stall_len) &&
                     (int'($urandom_range(0, 99)) >= stall_pct);
            bi.en = en_now;
            cur_resp = resp_pend;
            resp_pend = 0;
            if (cur_resp) begin
                bi.dout = mem[resp_addr] + (resp_bad ? 8'd1 : 8'd0);
                if (resp_bad) begin
                    halt = 1; fail_exp = 1; fpat = resp_pat; exp_at = n + 1;
                end else if (resp_final) begin
                    exp_at = n + 1;
                end
            end else begin
                bi.dout = 8'($urandom);
            end

            expv = '0;
            if (en_now && !halt && idx < exp_q.size()) begin
                op = exp_q[idx];
                idx++;
                if (op.w) begin
                    expv[29] = 1'b1;
                    expv[21:14] = op.d;
                    expv[13:12] = 2'b11;
                end else begin
                    expv[28] = 1'b1;
                    expv[11:4] = op.d;
                    resp_pend = 1; resp_addr = op.a; resp_pat = op.p;
                    resp_bad = (cmode == 1) || (rdno == corrupt_rd);
                    resp_final = (idx == exp_q.size());
                    rdno++;
                end
                expv[27:22] = 6'(op.a);
            end
            if (exp_at >= 0 && n >= exp_at) begin
                expv[3] = 1'b1;
                expv[2] = fail_exp;
            end
            tp_exp = fail_exp ? fpat : MARCH_CM_ENHANCED;
            expv[1:0] = (exp_at >= 0 && n >= exp_at) ? tp_exp : 2'b00;

            @(negedge clk);
            tp_obs = (exp_at >= 0 && n >= exp_at) ? bi.test_pattern : 2'b00;
            obs = {2'b00, bi.we, bi.re, bi.addr, bi.din, bi.wmask, bi.check,
                   bi.done, bi.fail, tp_obs};
            check($sformatf("%s cycle %0d", name, n), obs, expv);
            if (bi.we) mem[bi.addr] = bi.din;
            if (done_cyc < 0 && bi.done) done_cyc = n;
            if (fail_cyc < 0 && bi.fail) fail_cyc = n;
            if (exp_at >= 0 && n >= exp_at + 4) begin
                finished = 1;
                break;
            end
            if (bad - bad0 > 8) break;
        end
        check({name, " finished within budget"}, finished, 1);
    endtask

    initial begin
        int dc, fc;
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
        bi.rst = 1'b1; bi.en = 1'b0; bi.pattern_sel = ZERO_ONE; bi.dout = 8'h00;

        run_case("pass", ZERO_ONE, 0, -1, 0, 0, dc, fc);
        check("pass done cycle", dc, 1153);
        check("pass fail cycle", fc, -1);

        run_case("fail_zo", ZERO_ONE, 0, -1, 0, 1, dc, fc);
        check("fail_zo fail cycle", fc, 66);
        check("fail_zo done cycle", dc, 66);
        check("fail_zo test_pattern", bi.test_pattern, ZERO_ONE);

        bi.en = 1'b0;
        bi.pattern_sel = CHECKERBOARD;
        bi.rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("recover outputs",
              {bi.we, bi.re, bi.addr, bi.din, bi.wmask, bi.check, bi.done, bi.fail}, 0);
        check("recover test_pattern", bi.test_pattern, CHECKERBOARD);
        run_case("recover_run", CHECKERBOARD, 0, -1, 0, 0, dc, fc);
        check("recover done cycle", dc, 897);
        check("recover fail cycle", fc, -1);

        run_case("fail_march", MARCH_CM_ENHANCED, 0, -1, 0, 1, dc, fc);
        check("fail_march fail cycle", fc, 66);
        check("fail_march test_pattern", bi.test_pattern, MARCH_CM_ENHANCED);

        run_case("stall", ZERO_ONE, 0, 70, 5, 0, dc, fc);
        check("stall done cycle", dc, 1158);
        check("stall fail cycle", fc, -1);

        for (int r = 0; r < 6; r++) begin
            pattern_t sel;
            int pct, mode;
            sel  = pattern_t'($urandom_range(0, 2));
            pct  = int'($urandom_range(0, 30));
            mode = (r % 2 == 0) ? 2 : 0;
            run_case($sformatf("rand%0d", r), sel, pct, -1, 0, mode, dc, fc);
            if (mode == 0) check($sformatf("rand%0d clean", r), fc, -1);
            else           check($sformatf("rand%0d caught", r), (fc >= 0), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bist.md
# bist

Built-in self-test controller for one SRAM22 macro. It sequences the memory through a chain of test patterns and drives write/read commands with expected read data. It compares the SRAM read data against that expectation and reports done/fail together with the pattern that was running. It sits between the SRAM macro and the top-level test controller, and connects through the `bist_if` interface (`bist` modport).

## Interface
Module parameters:
- `MUX_RATIO`, default 4: column mux ratio. Rows = (MAX_ADDR+1)/MUX_RATIO; physical column = addr[$clog2(MUX_RATIO)-1:0]; physical row = the upper address bits.

Interface parameters (`bist_if`):
- `MAX_ADDR`, default 63: highest word address. Address width = $clog2(MAX_ADDR).
- `DATA_WIDTH`, default 8: word width.
- `MASK_WIDTH`, default 2: write-mask width.

Ports (via `bist_if.bist`):
- `clk`  in  1  the only clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable; operations advance only while high.
- `pattern_sel`  in  `bist_pattern_sel::pattern_t`  starting pattern, sampled while `rst`=1.
- `we`  out  1  SRAM write strobe.
- `re`  out  1  SRAM read strobe.
- `addr`  out  AddrWidth  SRAM word address.
- `din`  out  DATA_WIDTH  SRAM write data.
- `wmask`  out  MASK_WIDTH  write mask; all ones on writes.
- `check`  out  DATA_WIDTH  expected read data for the read issued this cycle.
- `dout`  in  DATA_WIDTH  SRAM read data, valid one cycle after `re`.
- `done`  out  1  test finished (pass or fail); sticky.
- `fail`  out  1  mismatch detected; sticky.
- `test_pattern`  out  `pattern_t`  pattern currently running, or the pattern that failed.

## Operation
- Pattern order: ZERO_ONE → CHECKERBOARD → MARCH_CM_ENHANCED → finish. The run starts at `pattern_sel` and executes that pattern and every later one.
- One SRAM operation per enabled cycle. "0" means all-zeros data and "1" means all-ones data. ⇑ is ascending addresses 0..MAX_ADDR; ⇓ is descending.
- ZERO_ONE: ⇑w0; ⇑r0; ⇑w1; ⇑r1.
- CHECKERBOARD: ⇑w(P); ⇑r(P); ⇑w(~P); ⇑r(~P).
  - P = all ones when row[0]^col[0]=1, else all zeros.
- MARCH_CM_ENHANCED: ⇑w0; ⇑(r0,w1); ⇑(r1,w0); ⇓(r0,w1); ⇓(r1,w0); ⇑r0. Both operations of an element act on the same address before the address advances.
- Write cycles: `we`=1, `re`=0, `wmask`=all ones.
- Read cycles: `re`=1, `we`=0, `check`=expected word.
- FSM states: IDLE (reset, or `en`=0 before start) → RUN → DONE.
- Any `en`=0 cycle during RUN is a stall: `we`=`re`=0 and counters hold. A read issued before the stall is still compared.
- Comparator: in the cycle after a read, compare `dout` against the registered `check`. On mismatch, set `fail` and `done` and go to DONE. `test_pattern` freezes on the pattern that issued the failing read. No further operations are issued.
- After the final read of MARCH_CM_ENHANCED is compared clean, set `done` with `fail`=0.
- In DONE: `we`=`re`=0. `done`/`fail` hold until `rst`.
- Reset mid-run aborts immediately. `pattern_sel` is re-sampled.
- Reset values: `we`=`re`=0, `addr`=0, `din`=0, `check`=0, `wmask`=0, `done`=0, `fail`=0, `test_pattern`=`pattern_sel`.

## Timing
- Call the first cycle with `rst`=0 and `en`=1 op 0.
- A read issued in cycle k is compared in cycle k+1. `fail`/`done` are visible from cycle k+2.
- Operation counts per pattern with N = MAX_ADDR+1 = 64:
  - ZERO_ONE: 4N = 256.
  - CHECKERBOARD: 4N = 256.
  - MARCH_CM_ENHANCED: 10N = 640.
- Full run from ZERO_ONE with no stalls: 1152 ops. The last read is in cycle 1151 and `done` is visible from cycle 1153.
- Address wrap: after address MAX_ADDR (⇑) or 0 (⇓), advance to the next element. After the last element, advance to the next pattern with no idle cycle.

## Structure
- Package `bist_pattern_sel`: `typedef enum logic [1:0] {ZERO_ONE, CHECKERBOARD, MARCH_CM_ENHANCED} pattern_t`.
- Interface `bist_if` #(MAX_ADDR, DATA_WIDTH, MASK_WIDTH) carries `clk` plus all the signals listed above.
  - Modport `bist`: `rst`/`en`/`pattern_sel`/`dout` as inputs.
  - Modport `sram`: mirror of `bist`.
- One sub-module, `bist_march_gen`, produces the per-pattern element, address and data sequence. The top module holds the FSM, the read-pipeline register and the comparator.

## Test plan
- Pass: `rst` for 16 cycles with `pattern_sel`=ZERO_ONE, then `en`=1; `dout`=`check` registered one cycle → `done`=1, `fail`=0 from cycle 1153.
- Fail: same, but `dout`=registered `check`+1 → `fail`=`done`=1 from cycle 66; `test_pattern`=ZERO_ONE; `we`=`re`=0 afterward.
- Start mid-chain: `pattern_sel`=MARCH_CM_ENHANCED with the corrupted `dout` → `fail`=1 and `test_pattern`=MARCH_CM_ENHANCED. The first read is at op 64, so `fail` is visible from cycle 66.
- Stall: drop `en` for 5 cycles during the ZERO_ONE r0 element → no strobes while low; the pass completes 5 cycles later (cycle 1158).
- Reset recovery: assert `rst` while `done`=`fail`=1 → all outputs return to reset values within one cycle, and a subsequent clean run passes.
- Address order: monitor `addr` during MARCH_CM_ENHANCED element 4 → descending 63..0, each address read and then written.
